// File: rtl/scan_test_pkg.sv
// Shared types and helpers for the scan test controller: FSM state encoding,
// counter width and a saturating increment.
package scan_test_pkg;

  localparam int unsigned CntW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPat,
    StLoad,
    StCapture,
    StUnload,
    StDone
  } ctrlStateT;

  function automatic logic [CntW-1:0] satInc(input logic [CntW-1:0] v);
    return (v == {CntW{1'b1}}) ? v : v + CntW'(1);
  endfunction

endpackage

// File: rtl/scan_shift_unit.sv
// Parallel-load shift register with serial out (bit 0 first) and a masked serial
// compare against the shifted data that raises a sticky mismatch flag.
module scan_shift_unit #(
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [Width-1:0] loadData,
  input  logic [Width-1:0] loadMask,
  input  logic             cmpEn,
  input  logic             cmpIn,
  output logic             serialOut,
  output logic             mismatch
);

  logic [Width-1:0] dataQ;
  logic [Width-1:0] maskQ;
  logic             stickyQ;
  logic             bitMis;

  assign serialOut = dataQ[0];
  assign bitMis    = cmpEn & maskQ[0] & (cmpIn ^ dataQ[0]);
  // Includes the current bit so a miss in the final shift cycle is seen at once.
  assign mismatch  = stickyQ | bitMis;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dataQ   <= '0;
      maskQ   <= '0;
      stickyQ <= 1'b0;
    end else if (load) begin
      dataQ   <= loadData;
      maskQ   <= loadMask;
      stickyQ <= 1'b0;
    end else if (shift) begin
      dataQ   <= {1'b0, dataQ[Width-1:1]};
      maskQ   <= {1'b0, maskQ[Width-1:1]};
      stickyQ <= stickyQ | bitMis;
    end
  end

endmodule

// File: rtl/scan_test_controller.sv
// Scan test controller: loads patterns into the CUT scan chain, pulses capture and
// grades the overlapped unload. Define SCAN_FAILLOG_EN to add first-fail reporting.
module scan_test_controller
  import scan_test_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned PI_W      = 49,
  parameter int unsigned PO_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 patValid,
  output logic                 patReady,
  input  logic                 patLast,
  input  logic [CHAIN_LEN-1:0] patScanIn,
  input  logic [PI_W-1:0]      patPI,
  input  logic [PO_W-1:0]      patExpPO,
  input  logic [CHAIN_LEN-1:0] patExpSO,
  input  logic [CHAIN_LEN-1:0] patMaskSO,
  output logic                 cutCe,
  output logic                 scanEn,
  output logic                 scanIn,
  input  logic                 scanOut,
  output logic [PI_W-1:0]      cutPI,
  input  logic [PO_W-1:0]      cutPO,
  output logic                 busy,
  output logic                 done,
  output logic [CntW-1:0]      passCnt,
  output logic [CntW-1:0]      failCnt
`ifdef SCAN_FAILLOG_EN
  ,
  output logic [CntW-1:0]      firstFailIdx,
  output logic                 firstFailValid
`endif
);

  localparam int unsigned IdxW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CHAIN_LEN - 1);

  ctrlStateT            stateQ, stateD;
  logic [IdxW-1:0]      idxQ;
  logic                 lastQ;
  logic [PI_W-1:0]      piQ;
  logic [PO_W-1:0]      curExpPOQ;
  logic [CHAIN_LEN-1:0] curExpSOQ;
  logic [CHAIN_LEN-1:0] curMaskQ;
  logic                 prevValidQ;
  logic                 prevPoFailQ;
  logic                 doneQ;
  logic [CntW-1:0]      passQ;
  logic [CntW-1:0]      failQ;

  logic shifting, lastShift;
  logic hsk, sessStart, siShift, expLoad, expShift, cmpEn, scanSel, verdict, doneSet;
  logic siSerial, expMismatch, patFail;
  logic unusedSiMismatch, unusedExpSerial;

  assign shifting  = (stateQ == StLoad) || (stateQ == StUnload);
  assign lastShift = shifting && (idxQ == LastIdx);
  assign patFail   = expMismatch | prevPoFailQ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    patReady  = 1'b0;
    cutCe     = 1'b0;
    scanEn    = 1'b0;
    scanSel   = 1'b0;
    hsk       = 1'b0;
    sessStart = 1'b0;
    siShift   = 1'b0;
    expShift  = 1'b0;
    expLoad   = 1'b0;
    cmpEn     = 1'b0;
    verdict   = 1'b0;
    doneSet   = 1'b0;
    case (stateQ)
      StIdle: begin
        if (start) begin
          sessStart = 1'b1;
          stateD    = StWaitPat;
        end
      end
      StWaitPat: begin
        patReady = 1'b1;
        if (patValid) begin
          hsk    = 1'b1;
          stateD = StLoad;
        end
      end
      StLoad: begin
        cutCe    = 1'b1;
        scanEn   = 1'b1;
        scanSel  = 1'b1;
        siShift  = 1'b1;
        expShift = 1'b1;
        // No previous response exists for the first pattern of a session.
        cmpEn    = prevValidQ;
        if (lastShift) begin
          verdict = prevValidQ;
          stateD  = StCapture;
        end
      end
      StCapture: begin
        cutCe   = 1'b1;
        expLoad = 1'b1;
        stateD  = lastQ ? StUnload : StWaitPat;
      end
      StUnload: begin
        cutCe    = 1'b1;
        scanEn   = 1'b1;
        expShift = 1'b1;
        cmpEn    = 1'b1;
        if (lastShift) begin
          verdict = 1'b1;
          doneSet = 1'b1;
          stateD  = StDone;
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idxQ <= '0;
    end else if (shifting && !lastShift) begin
      idxQ <= idxQ + IdxW'(1);
    end else begin
      idxQ <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lastQ     <= 1'b0;
      piQ       <= '0;
      curExpPOQ <= '0;
      curExpSOQ <= '0;
      curMaskQ  <= '0;
    end else if (hsk) begin
      lastQ     <= patLast;
      piQ       <= patPI;
      curExpPOQ <= patExpPO;
      curExpSOQ <= patExpSO;
      curMaskQ  <= patMaskSO;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      passQ       <= '0;
      failQ       <= '0;
      doneQ       <= 1'b0;
      prevValidQ  <= 1'b0;
      prevPoFailQ <= 1'b0;
    end else if (sessStart) begin
      passQ       <= '0;
      failQ       <= '0;
      doneQ       <= 1'b0;
      prevValidQ  <= 1'b0;
      prevPoFailQ <= 1'b0;
    end else begin
      if (verdict) begin
        if (patFail) begin
          failQ <= satInc(failQ);
        end else begin
          passQ <= satInc(passQ);
        end
      end
      if (expLoad) begin
        prevValidQ  <= 1'b1;
        prevPoFailQ <= (cutPO != curExpPOQ);
      end
      if (doneSet) begin
        doneQ <= 1'b1;
      end
    end
  end

  scan_shift_unit #(
    .Width(CHAIN_LEN)
  ) siUnit (
    .clk      (clk),
    .rst      (rst),
    .load     (hsk),
    .shift    (siShift),
    .loadData (patScanIn),
    .loadMask ('0),
    .cmpEn    (1'b0),
    .cmpIn    (1'b0),
    .serialOut(siSerial),
    .mismatch (unusedSiMismatch)
  );

  // Holds the previous pattern's expected response while the chain shifts it out.
  scan_shift_unit #(
    .Width(CHAIN_LEN)
  ) expUnit (
    .clk      (clk),
    .rst      (rst),
    .load     (expLoad),
    .shift    (expShift),
    .loadData (curExpSOQ),
    .loadMask (curMaskQ),
    .cmpEn    (cmpEn),
    .cmpIn    (scanOut),
    .serialOut(unusedExpSerial),
    .mismatch (expMismatch)
  );

`ifdef SCAN_FAILLOG_EN
  logic [CntW-1:0] verdictIdxQ;
  logic [CntW-1:0] ffIdxQ;
  logic            ffValidQ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      verdictIdxQ <= '0;
      ffIdxQ      <= '0;
      ffValidQ    <= 1'b0;
    end else if (sessStart) begin
      verdictIdxQ <= '0;
      ffIdxQ      <= '0;
      ffValidQ    <= 1'b0;
    end else if (verdict) begin
      verdictIdxQ <= satInc(verdictIdxQ);
      if (patFail && !ffValidQ) begin
        ffValidQ <= 1'b1;
        ffIdxQ   <= verdictIdxQ;
      end
    end
  end

  assign firstFailIdx   = ffIdxQ;
  assign firstFailValid = ffValidQ;
`endif

  assign busy    = (stateQ == StWaitPat) || (stateQ == StLoad) ||
                   (stateQ == StCapture) || (stateQ == StUnload);
  assign done    = doneQ;
  assign passCnt = passQ;
  assign failCnt = failQ;
  assign cutPI   = piQ;
  assign scanIn  = scanSel & siSerial;

endmodule

// File: doc/scan_test_controller.md
# scan_test_controller

On-chip scan test controller for the scan-ready SAYAC netlist. It accepts test patterns from a pattern source over a valid/ready stream and shifts each pattern into the CUT's scan chain while driving the CUT's primary inputs. It then pulses one capture cycle, shifts the response out (overlapped with the next load) and compares scan-out and primary outputs against expected values. Pass/fail counts feed fault-coverage bookkeeping for the generated fault list.

## Interface

Parameters:
- CHAIN_LEN, 64: scan chain length in flops.
- PI_W, 49: CUT primary-input width (readyMEM, dataBusIn, p1TRF, p2TRF).
- PO_W, 16: compared CUT primary-output width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse that begins a session and clears counters; ignored while busy.
- patValid  in  1  pattern word valid.
- patReady  out  1  controller accepts a pattern word.
- patLast  in  1  marks the final pattern of the session.
- patScanIn  in  CHAIN_LEN  scan-in vector; bit 0 is shifted first.
- patPI  in  PI_W  primary-input vector.
- patExpPO  in  PO_W  expected primary outputs at capture.
- patExpSO  in  CHAIN_LEN  expected scan-out; bit i is compared in shift cycle i.
- patMaskSO  in  CHAIN_LEN  1 = compare the bit, 0 = don't-care.
- cutCe  out  1  CUT clock enable; CUT flops update only when it is 1.
- scanEn  out  1  CUT scan-enable.
- scanIn  out  1  serial scan data to CUT.
- scanOut  in  1  serial scan data from CUT.
- cutPI  out  PI_W  CUT primary inputs.
- cutPO  in  PO_W  CUT primary outputs.
- busy  out  1  session in progress.
- done  out  1  session complete; held until the next start.
- passCnt  out  16  passing patterns, saturating.
- failCnt  out  16  failing patterns, saturating.

## Operation

States: IDLE, WAIT_PAT, LOAD, CAPTURE, UNLOAD, DONE.

- **IDLE**: waits for start. On start, clear counters and done, then go to WAIT_PAT.
- **WAIT_PAT**:
  - patReady=1, cutCe=0.
  - On handshake, latch all pattern fields and go to LOAD.
  - If the previous pattern's unload is still pending, its response stays frozen in the CUT because cutCe=0.
- **LOAD**: CHAIN_LEN cycles with cutCe=1 and scanEn=1.
  - scanIn carries patScanIn[i] in cycle i.
  - In the same cycle, scanOut is compared with the previous pattern's expSO[i] where its mask bit is 1. This is skipped for the first pattern of a session.
  - cutPI is driven from the latched patPI from the first LOAD cycle onward.
  - After the last cycle, the previous pattern's verdict is final.
- **CAPTURE**: one cycle, cutCe=1, scanEn=0.
  - cutPO is compared with expPO in this cycle.
  - The current pattern's expSO, mask and PO result move to the "previous" registers.
  - Next state is UNLOAD if patLast was latched, else WAIT_PAT.
- **UNLOAD**: CHAIN_LEN cycles, scanEn=1, scanIn=0, compare as in LOAD. Then go to DONE.
- **DONE**: done=1, busy=0. Return to IDLE the next cycle; done stays held.

Verdict rules:
- A pattern fails on any masked scan-out mismatch or any PO mismatch. The verdict increments failCnt or passCnt exactly once.
- Counters saturate at 16'hFFFF.

Input handling:
- patValid outside WAIT_PAT is ignored (patReady=0).
- start during busy is ignored.

## Timing

- Reset values: all outputs 0 (patReady, cutCe, scanEn, scanIn, cutPI, busy, done, passCnt, failCnt). State is IDLE.
- rst low mid-session aborts immediately. The in-flight pattern is not counted.
- start at cycle t gives busy=1 and patReady=1 at t+1.
- A single-pattern session takes 2·CHAIN_LEN+3 cycles from handshake to done:
  - 1 handshake cycle
  - CHAIN_LEN LOAD cycles
  - 1 CAPTURE cycle
  - CHAIN_LEN UNLOAD cycles
  - 1 cycle to DONE
- Back-to-back patterns, source always valid: one pattern per CHAIN_LEN+2 cycles.
- A counter update for pattern k is visible the cycle after the last shift cycle of pattern k+1's LOAD, or after UNLOAD for the last pattern.
- Shift index counter width is clog2(CHAIN_LEN). Index wraps to 0 at each LOAD/UNLOAD entry.

## Configuration

SCAN_FAILLOG_EN:
- **Defined**: adds output ports firstFailIdx (16, index of the first failing pattern, 0-based) and firstFailValid (1). Both clear on start and are set once per session, on the first fail verdict.
- **Undefined**: these ports and the pattern-index counter are absent. All other behaviour is identical.

## Structure

- Package scan_test_pkg holds:
  - state encoding (6 states)
  - counter width (16)
  - saturate-increment function
- Sub-module scan_shift_unit: CHAIN_LEN parallel-load shift register with serial out, plus a masked serial compare that raises a sticky mismatch flag. The controller instantiates it for scan-in data and expected/mask data.

## Test plan

All scenarios use CHAIN_LEN=8, PI_W=4, PO_W=4, with a behavioural 8-flop scan chain model plus PO=PI.

1. Single pattern: scanIn 8'hA5, expSO 8'hA5 with the model looping chain contents, mask 8'hFF, PI=4'h3, expPO=4'h3 → passCnt=1, failCnt=0, done 19 cycles after the handshake.
2. Same pattern with expPO=4'h4 → failCnt=1; firstFailIdx=0 when SCAN_FAILLOG_EN is defined.
3. Scan-out bit 5 flipped with mask 8'hDF → pass; with mask 8'hFF → fail.
4. Three back-to-back patterns with the second corrupted → passCnt=2, failCnt=1, firstFailIdx=1, patReady spacing of 10 cycles.
5. rst low in LOAD cycle 3 → next cycle all outputs 0, counters 0, state IDLE. A subsequent start runs normally.
6. start pulsed while busy, and patValid held in LOAD → no effect on counters or handshake count.
